// File: rtl/uart_loopback_ctrl_if.sv
// Handshake bundle between the loopback sequencer and the UART TX/RX pair plus
// the run control/status lines.
//   master : sequencer side (drives Tx_*, enables, baud and status)
//   slave  : UART / test-harness side (drives start, Tx_BUSY and Rx_*)
interface uart_loopback_ctrl_if;
  logic       start;
  logic       Tx_BUSY;
  logic       Rx_VALID;
  logic [7:0] Rx_DATA;
  logic       Rx_FERROR;
  logic       Rx_PERROR;
  logic [7:0] Tx_DATA;
  logic       Tx_WR;
  logic       Tx_EN;
  logic       Rx_EN;
  logic [2:0] baud_select;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic [7:0] sym_count;

  modport master (
    input  start, Tx_BUSY, Rx_VALID, Rx_DATA, Rx_FERROR, Rx_PERROR,
    output Tx_DATA, Tx_WR, Tx_EN, Rx_EN, baud_select, busy, done, pass, err_count, sym_count
  );

  modport slave (
    output start, Tx_BUSY, Rx_VALID, Rx_DATA, Rx_FERROR, Rx_PERROR,
    input  Tx_DATA, Tx_WR, Tx_EN, Rx_EN, baud_select, busy, done, pass, err_count, sym_count
  );
endinterface

// File: rtl/uart_loopback_ctrl.sv
// UART loopback self-test sequencer. On start it enables TX/RX, selects the
// baud rate and sends NUM_SYMBOLS bytes from the repeating pattern
// AA,55,CC,89. Each byte is compared with the received echo; mismatches,
// framing/parity errors and timeouts are counted and pass/fail is reported.
// Ports:
//   i_clk    : system clock, rising edge
//   i_reset  : asynchronous active-high reset
//   io_bus   : uart_loopback_ctrl_if.master (start, TX/RX handshake, status)
module uart_loopback_ctrl #(
  parameter int unsigned NUM_SYMBOLS    = 8,
  parameter int unsigned TIMEOUT_CYCLES = 500000,
  parameter logic [2:0]  BAUD_SEL       = 3'b111
) (
  input logic                  i_clk,
  input logic                  i_reset,
  uart_loopback_ctrl_if.master io_bus
);

  localparam int unsigned TimerW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] NumSym = 8'(NUM_SYMBOLS);

  typedef enum logic [3:0] {
    StIdle, StSetup, StLoad, StWaitAccept, StWaitRx, StCheck, StErr, StNext, StDone
  } state_e;

  state_e            r_state, w_state_next;
  logic [7:0]        r_tx_data, w_tx_data_next;
  logic              r_en, w_en_next;
  logic [2:0]        r_baud, w_baud_next;
  logic              r_busy, w_busy_next;
  logic              r_done, w_done_next;
  logic [7:0]        r_err, w_err_next;
  logic [7:0]        r_sym, w_sym_next;
  logic [1:0]        r_idx, w_idx_next;
  logic [TimerW-1:0] r_timer, w_timer_next;
  logic              r_rx_valid_q;
  logic [7:0]        r_rx_data, w_rx_data_next;
  logic              r_rx_ferr, w_rx_ferr_next;
  logic              r_rx_perr, w_rx_perr_next;

  logic       w_rx_rise;
  logic       w_timer_hit;
  logic [7:0] w_err_inc;
  logic [7:0] w_sym_inc;

  function automatic logic [7:0] pattern(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'hAA;
      2'd1:    return 8'h55;
      2'd2:    return 8'hCC;
      default: return 8'h89;
    endcase
  endfunction

  // Only a 0->1 transition of the level-type valid counts as a reception.
  assign w_rx_rise   = io_bus.Rx_VALID & ~r_rx_valid_q;
  assign w_timer_hit = (r_timer == TimerLast);
  assign w_err_inc   = (r_err == 8'hFF) ? r_err : r_err + 8'd1;
  assign w_sym_inc   = r_sym + 8'd1;

  always_comb begin
    w_state_next   = r_state;
    w_tx_data_next = r_tx_data;
    w_en_next      = r_en;
    w_baud_next    = r_baud;
    w_busy_next    = r_busy;
    w_done_next    = r_done;
    w_err_next     = r_err;
    w_sym_next     = r_sym;
    w_idx_next     = r_idx;
    w_timer_next   = r_timer;
    w_rx_data_next = r_rx_data;
    w_rx_ferr_next = r_rx_ferr;
    w_rx_perr_next = r_rx_perr;

    unique case (r_state)
      StIdle, StDone: begin
        if (io_bus.start) begin
          w_state_next = StSetup;
          w_err_next   = '0;
          w_sym_next   = '0;
          w_idx_next   = '0;
          w_busy_next  = 1'b1;
          w_done_next  = 1'b0;
          w_en_next    = 1'b1;
          w_baud_next  = BAUD_SEL;
        end
      end
      StSetup: begin
        if (!io_bus.Tx_BUSY) begin
          w_state_next   = StLoad;
          // Loaded here so the byte is stable for the whole write-strobe cycle.
          w_tx_data_next = pattern(r_idx);
        end
      end
      StLoad: begin
        w_state_next = StWaitAccept;
        w_timer_next = '0;
      end
      StWaitAccept: begin
        if (io_bus.Tx_BUSY) begin
          w_state_next = StWaitRx;
          w_timer_next = '0;
        end else if (w_timer_hit) begin
          w_state_next = StErr;
        end else begin
          w_timer_next = r_timer + TimerW'(1);
        end
      end
      StWaitRx: begin
        // A reception in the timeout cycle takes priority over the timeout.
        if (w_rx_rise) begin
          w_state_next   = StCheck;
          w_rx_data_next = io_bus.Rx_DATA;
          w_rx_ferr_next = io_bus.Rx_FERROR;
          w_rx_perr_next = io_bus.Rx_PERROR;
        end else if (w_timer_hit) begin
          w_state_next = StErr;
        end else begin
          w_timer_next = r_timer + TimerW'(1);
        end
      end
      StCheck: begin
        if ((r_rx_data != r_tx_data) || r_rx_ferr || r_rx_perr) begin
          w_err_next = w_err_inc;
        end
        w_state_next = StNext;
      end
      StErr: begin
        w_err_next   = w_err_inc;
        w_state_next = StNext;
      end
      StNext: begin
        w_sym_next = w_sym_inc;
        w_idx_next = r_idx + 2'd1;
        if (w_sym_inc == NumSym) begin
          w_state_next = StDone;
          w_busy_next  = 1'b0;
          w_done_next  = 1'b1;
          w_en_next    = 1'b0;
        end else begin
          w_state_next = StSetup;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_tx_data    <= '0;
      r_en         <= 1'b0;
      r_baud       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= '0;
      r_sym        <= '0;
      r_idx        <= '0;
      r_timer      <= '0;
      r_rx_valid_q <= 1'b0;
      r_rx_data    <= '0;
      r_rx_ferr    <= 1'b0;
      r_rx_perr    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_tx_data    <= w_tx_data_next;
      r_en         <= w_en_next;
      r_baud       <= w_baud_next;
      r_busy       <= w_busy_next;
      r_done       <= w_done_next;
      r_err        <= w_err_next;
      r_sym        <= w_sym_next;
      r_idx        <= w_idx_next;
      r_timer      <= w_timer_next;
      r_rx_valid_q <= io_bus.Rx_VALID;
      r_rx_data    <= w_rx_data_next;
      r_rx_ferr    <= w_rx_ferr_next;
      r_rx_perr    <= w_rx_perr_next;
    end
  end

  assign io_bus.Tx_DATA     = r_tx_data;
  assign io_bus.Tx_WR       = (r_state == StLoad);
  assign io_bus.Tx_EN       = r_en;
  assign io_bus.Rx_EN       = r_en;
  assign io_bus.baud_select = r_baud;
  assign io_bus.busy        = r_busy;
  assign io_bus.done        = r_done;
  assign io_bus.pass        = r_done & (r_err == 8'd0);
  assign io_bus.err_count   = r_err;
  assign io_bus.sym_count   = r_sym;

endmodule

// File: doc/uart_loopback_ctrl.md
Name: uart_loopback_ctrl

Overview:
Sequencer for a loopback self-test of the UART transmitter/receiver pair. On a start pulse it enables both sides and selects the baud rate. It then writes a fixed four-symbol pattern (AA, 55, CC, 89, repeating) into the transmitter one symbol at a time. After each symbol it waits for the receiver, compares the received byte and counts errors, and finally reports pass/fail.

Parameters:
NUM_SYMBOLS, 8, total symbols per test run (1..255); pattern index wraps modulo 4.
TIMEOUT_CYCLES, 500000, clk cycles allowed in each wait state before declaring a timeout.
BAUD_SEL, 3'b111, value driven on baud_select during a run.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to begin a run; ignored unless state is IDLE or DONE
Tx_BUSY  input  1  transmitter busy flag
Rx_VALID  input  1  receiver data valid (level, may stay high several cycles)
Rx_DATA  input  8  received byte
Rx_FERROR  input  1  receiver framing error, sampled with Rx_VALID
Rx_PERROR  input  1  receiver parity error, sampled with Rx_VALID
Tx_DATA  output  8  byte presented to transmitter
Tx_WR  output  1  one-cycle write strobe to transmitter
Tx_EN  output  1  transmitter enable
Rx_EN  output  1  receiver enable
baud_select  output  3  baud selection for both sides
busy  output  1  high while a run is in progress
done  output  1  high in DONE until next start or reset
pass  output  1  valid when done=1: err_count==0
err_count  output  8  errors in current/last run, saturates at 255
sym_count  output  8  symbols completed (checked or timed out) in current run

Behaviour:
- Reset values: Tx_DATA=0, Tx_WR=0, Tx_EN=0, Rx_EN=0, baud_select=0, busy=0, done=0, pass=0, err_count=0, sym_count=0, state=IDLE, pattern index=0, timer=0.
- Reset asserted mid-run aborts immediately to IDLE with the reset values; no partial result is retained.
- Rx_VALID rising-edge detection uses a registered copy of Rx_VALID. Only a 0->1 transition counts as a reception.
- States:
  - IDLE: all enables low. start -> SETUP. Clear err_count, sym_count and index. Set busy=1, Tx_EN=Rx_EN=1, baud_select=BAUD_SEL.
  - SETUP: one cycle for the enables to settle -> LOAD when Tx_BUSY=0; otherwise stay.
  - LOAD: drive Tx_DATA=pattern[index] and Tx_WR=1 for exactly this one cycle -> WAIT_ACCEPT. Clear the timer.
  - WAIT_ACCEPT: Tx_BUSY=1 -> WAIT_RX, clear timer. If the timer reaches TIMEOUT_CYCLES-1 -> ERR.
  - WAIT_RX: Rx_VALID rising edge -> CHECK, capturing Rx_DATA, Rx_FERROR and Rx_PERROR. If the timer reaches TIMEOUT_CYCLES-1 -> ERR. If a rising edge and the timeout occur in the same cycle, the edge wins.
  - CHECK: if the captured byte differs from the sent byte, or FERROR or PERROR is set, err_count+1 (saturating). Then -> NEXT.
  - ERR: err_count+1 (saturating) -> NEXT.
  - NEXT: sym_count+1 and index=(index+1) mod 4. If sym_count+1==NUM_SYMBOLS -> DONE. Otherwise -> SETUP, which waits for Tx_BUSY=0 before the next write.
  - DONE: busy=0, done=1, pass=(err_count==0); Tx_EN=Rx_EN=0, baud_select holds. start -> new run, identical to start from IDLE.
- A start received while busy=1 is ignored.
- Rx_VALID edges outside WAIT_RX are ignored; the edge detector still updates.
- Tx_WR is never high for two consecutive cycles. Exactly NUM_SYMBOLS write strobes occur per run unless reset intervenes.
- Latency from start to the first Tx_WR is 2 cycles (IDLE->SETUP->LOAD) when Tx_BUSY=0.

Test Plan:
- Clean loopback model (Tx_BUSY high for 100 cycles after Tx_WR, Rx_VALID pulse echoing the byte at cycle 90), NUM_SYMBOLS=8 -> Tx_DATA sequence AA,55,CC,89,AA,55,CC,89; 8 Tx_WR pulses of 1 cycle each; done=1, pass=1, err_count=0, sym_count=8.
- Echo model corrupts the 3rd symbol (returns CD instead of CC) -> err_count=1, pass=0, sym_count=8.
- Rx_VALID never asserted, TIMEOUT_CYCLES=50, NUM_SYMBOLS=2 -> each symbol times out after 50 cycles in WAIT_RX; err_count=2, done=1, pass=0.
- Rx_PERROR=1 with a correct byte on symbol 1 -> err_count=1. Rx_VALID held high 5 cycles -> counted once only.
- start pulsed again mid-run -> ignored, sym_count continues. Reset asserted in WAIT_RX -> all outputs return to reset values at once. A following start -> a fresh run with Tx_DATA=AA first.
- Tx_BUSY stuck low after Tx_WR, TIMEOUT_CYCLES=50 -> ERR via WAIT_ACCEPT timeout, err_count increments. Rx_VALID edge coinciding with the timeout cycle in WAIT_RX -> treated as a reception, not a timeout.
